axi_lite_mem_responder: RTL
===========================

Name: axi_lite_mem_responder

Overview:
- Single-beat AXI4 subordinate. Bridges one 32-bit AXI initiator (the core's memory-path AXI master) to a simple synchronous word-addressed SRAM port.
- Implements AXI exclusive access (awlock/arlock, EXOKAY). LR/SC and AMO read-modify-write sequences from the core therefore resolve correctly against local memory.
- Sits at the far end of the core's AXI bus, in front of on-chip data RAM.

Parameters:
ADDR_W, 32, AXI byte-address width. Memory word address is ADDR_W-2 bits.
ID_W, 1, width of awid/arid/bid/rid.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
s_axi_awvalid/awready  in/out  1  write-address handshake
s_axi_awaddr  in  ADDR_W  write byte address; bits [1:0] ignored
s_axi_awid  in  ID_W  write ID
s_axi_awlock  in  1  exclusive write
s_axi_wvalid/wready  in/out  1  write-data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid/bready  out/in  1  write-response handshake
s_axi_bresp  out  2  00 OKAY, 01 EXOKAY
s_axi_bid  out  ID_W  echoed awid
s_axi_arvalid/arready  in/out  1  read-address handshake
s_axi_araddr  in  ADDR_W  read byte address
s_axi_arid  in  ID_W  read ID
s_axi_arlock  in  1  exclusive read
s_axi_rvalid/rready  out/in  1  read-response handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 01 EXOKAY
s_axi_rid  out  ID_W  echoed arid
s_axi_rlast  out  1  tied 1 (single beat)
mem_req  out  1  SRAM access strobe
mem_we  out  1  1 = write
mem_addr  out  ADDR_W-2  word address
mem_be  out  4  byte enables
mem_wdata  out  32  write data
mem_rdata  in  32  valid exactly one cycle after a read mem_req

Behaviour:
- Reset (rst_n low, async):
  - All valid/ready outputs 0; bresp/rresp 00; rdata 0.
  - AW/W/AR holding slots empty; reservation invalid; state IDLE; priority bit = write.
  - Reset mid-transaction drops the transaction silently.
- Slots:
  - AW, W and AR each have one holding register (address/ID/lock or data/strobe).
  - The matching ready output is the registered inverse of slot-full.
  - A handshake fills the slot. The slot empties when the FSM consumes it.
  - AW and W are accepted independently and in either order.
- FSM states: IDLE, READ_WAIT, READ_RESP, WRITE_RESP.
- IDLE selects a candidate each cycle:
  - Write candidate: AW and W slots both full.
  - Read candidate: AR slot full.
  - If both are candidates, the priority bit chooses. The bit toggles to the other type after each served access (round robin).
- Write issue (IDLE, combinational mem_req=1, mem_we=1, mem_be=wstrb):
  - Normal write: memory write issued, bresp=00. Clears the reservation if word addresses match.
  - Exclusive write, reservation valid and word address match: memory write issued, bresp=01, reservation cleared.
  - Exclusive write that fails: mem_req=0 (no write), bresp=00, reservation cleared.
  - Next state WRITE_RESP. bvalid=1 from the next edge; both slots freed.
  - Minimum latency: bvalid one cycle after the later of the AW/W handshakes.
- Read issue (IDLE, mem_req=1, mem_we=0):
  - Exclusive read: sets reservation to araddr[ADDR_W-1:2].
  - Next state READ_WAIT, AR slot freed.
- READ_WAIT: capture mem_rdata into rdata; rresp=01 if the read was locked, else 00; rvalid=1; go to READ_RESP.
  - Minimum latency: rvalid two cycles after the AR handshake.
- READ_RESP / WRITE_RESP:
  - Hold valid, data and ID stable until ready.
  - On handshake, deassert valid and return to IDLE.
  - No new issue on the handshake cycle itself.
- Reservation granularity is one 32-bit word. There is a single reservation, not tracked per ID.

Optional Feature:
AXI_RESPONDER_EXCLUSIVE_EN
- Defined: exclusive monitor as described above.
- Undefined: no reservation register. awlock/arlock are ignored, and every access completes as normal with OKAY.
  - Exclusive writes still perform the memory write and return 00. This is AXI-compliant "exclusive not supported"; the initiator sees SC failure.

Decomposition:
- Shared package (riscv_types or an axi package): axi_resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the responder state enum.
- Sub-module axi_excl_monitor: holds the reservation; inputs set/check/clear/addr; output match.
- Slot registers stay inline.

Test Plan:
- Reset then read: write 0xDEADBEEF to word 0x40 (wstrb F); read araddr 0x100 -> rdata=0xDEADBEEF, rresp=00, rvalid two cycles after AR handshake.
- Decoupled write: W presented 3 cycles before AW, wstrb=0x3, wdata=0x1234ABCD over 0xFFFFFFFF -> memory reads 0xFFFFABCD, bresp=00, exactly one bvalid.
- LR/SC success: locked read 0x200, then locked write 0x200 data 5 -> rresp=01, bresp=01, memory=5.
- SC failure: locked read 0x200, normal write 0x200, locked write 0x200 data 7 -> bresp=00, no mem_req on the locked write, memory unchanged.
- Simultaneous AR and AW+W with rready/bready held low for 4 cycles -> accesses alternate per the priority bit, valid/data stable while stalled, no lost response.
- rst_n asserted while in READ_RESP -> rvalid=0 immediately, all readies 0; after release, a fresh transaction completes normally.

Source files
------------

// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared types for the AXI memory responder.
// Response codes, FSM states and arbitration constants.
package axi_lite_mem_responder_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    READ_WAIT  = 2'b01,
    READ_RESP  = 2'b10,
    WRITE_RESP = 2'b11
  } rsp_state_t;

  localparam logic PRIO_WRITE = 1'b0;
  localparam logic PRIO_READ  = 1'b1;

endpackage

// File: rtl/axi_excl_monitor.sv
// Single word-granular reservation for AXI exclusive access.
// Only built when AXI_RESPONDER_EXCLUSIVE_EN is defined.
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
module axi_excl_monitor #(
  parameter int AW = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic          check,
  input  logic          clear,
  input  logic [AW-1:0] addr,
  output logic          match
);

  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
    end else if (set) begin
      rsv_valid <= 1'b1;
      rsv_addr  <= addr;
    end else if (clear) begin
      rsv_valid <= 1'b0;
    end
  end

  assign match = check & rsv_valid & (rsv_addr == addr);

endmodule
`endif

// File: rtl/axi_lite_mem_responder.sv
// Single-beat AXI4 subordinate in front of a word-addressed SRAM.
// Define AXI_RESPONDER_EXCLUSIVE_EN to enable the exclusive monitor.
module axi_lite_mem_responder
  import axi_lite_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic              s_axi_awlock,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  output logic [ID_W-1:0]   s_axi_bid,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic              s_axi_arlock,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic              s_axi_rlast,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WA_W = ADDR_W - 2;

  rsp_state_t state, state_d;

  logic            aw_full, aw_full_d, aw_hs;
  logic [WA_W-1:0] aw_addr;
  logic [ID_W-1:0] aw_id;
  logic            aw_lock;

  logic            w_full, w_full_d, w_hs;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;

  logic            ar_full, ar_full_d, ar_hs;
  logic [WA_W-1:0] ar_addr;
  logic [ID_W-1:0] ar_id;
  logic            ar_lock;

  logic      wr_cand, rd_cand;
  logic      issue_wr, issue_rd;
  logic      prio_rd;
  axi_resp_t wr_resp;
  axi_resp_t bresp_q, rresp_q;

  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign aw_full_d = aw_hs | (aw_full & ~issue_wr);
  assign w_full_d  = w_hs | (w_full & ~issue_wr);
  assign ar_full_d = ar_hs | (ar_full & ~issue_rd);

  // ready is registered from the next-cycle fullness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full       <= 1'b0;
      s_axi_awready <= 1'b0;
      aw_addr       <= '0;
      aw_id         <= '0;
      aw_lock       <= 1'b0;
    end else begin
      aw_full       <= aw_full_d;
      s_axi_awready <= ~aw_full_d;
      if (aw_hs) begin
        aw_addr <= s_axi_awaddr[ADDR_W-1:2];
        aw_id   <= s_axi_awid;
        aw_lock <= s_axi_awlock;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full       <= 1'b0;
      s_axi_wready <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
    end else begin
      w_full       <= w_full_d;
      s_axi_wready <= ~w_full_d;
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_full       <= 1'b0;
      s_axi_arready <= 1'b0;
      ar_addr       <= '0;
      ar_id         <= '0;
      ar_lock       <= 1'b0;
    end else begin
      ar_full       <= ar_full_d;
      s_axi_arready <= ~ar_full_d;
      if (ar_hs) begin
        ar_addr <= s_axi_araddr[ADDR_W-1:2];
        ar_id   <= s_axi_arid;
        ar_lock <= s_axi_arlock;
      end
    end
  end

  assign wr_cand = aw_full & w_full;
  assign rd_cand = ar_full;

  assign issue_wr = (state == IDLE) & wr_cand
                  & (~rd_cand | (prio_rd == PRIO_WRITE));
  assign issue_rd = (state == IDLE) & rd_cand & ~issue_wr;

`ifdef AXI_RESPONDER_EXCLUSIVE_EN
  logic            excl_set, excl_clear, excl_match;
  logic            rd_lock;
  logic [WA_W-1:0] excl_addr;

  assign excl_addr = issue_rd ? ar_addr : aw_addr;

  axi_excl_monitor #(
    .AW (WA_W)
  ) u_excl (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (excl_set),
    .check (issue_wr),
    .clear (excl_clear),
    .addr  (excl_addr),
    .match (excl_match)
  );
`else
  logic unused_lock;
  assign unused_lock = aw_lock ^ ar_lock;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (issue_wr)      state_d = WRITE_RESP;
        else if (issue_rd) state_d = READ_WAIT;
      end
      READ_WAIT:  state_d = READ_RESP;
      READ_RESP:  if (s_axi_rready) state_d = IDLE;
      WRITE_RESP: if (s_axi_bready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ar_addr;
    mem_be    = 4'hF;
    mem_wdata = w_data;
    wr_resp   = OKAY;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
    excl_set   = 1'b0;
    excl_clear = 1'b0;
`endif
    if (issue_wr) begin
      mem_req  = 1'b1;
      mem_we   = 1'b1;
      mem_addr = aw_addr;
      mem_be   = w_strb;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
      // a failed exclusive write must not touch memory
      excl_clear = aw_lock | excl_match;
      if (aw_lock) begin
        mem_req = excl_match;
        wr_resp = excl_match ? EXOKAY : OKAY;
      end
`endif
    end else if (issue_rd) begin
      mem_req = 1'b1;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
      excl_set = ar_lock;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_rd     <= PRIO_WRITE;
      bresp_q     <= OKAY;
      s_axi_bid   <= '0;
      rresp_q     <= OKAY;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
      rd_lock     <= 1'b0;
`endif
    end else begin
      if (issue_wr) begin
        prio_rd   <= PRIO_READ;
        bresp_q   <= wr_resp;
        s_axi_bid <= aw_id;
      end
      if (issue_rd) begin
        prio_rd   <= PRIO_WRITE;
        s_axi_rid <= ar_id;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
        rd_lock   <= ar_lock;
`endif
      end
      if (state == READ_WAIT) begin
        s_axi_rdata <= mem_rdata;
`ifdef AXI_RESPONDER_EXCLUSIVE_EN
        rresp_q     <= rd_lock ? EXOKAY : OKAY;
`else
        rresp_q     <= OKAY;
`endif
      end
    end
  end

  assign s_axi_bvalid = (state == WRITE_RESP);
  assign s_axi_rvalid = (state == READ_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = 1'b1;

endmodule
